// File: rtl/unidad_salto.sv
// unidad_salto: branch resolution unit between decode and fetch.
// It accepts one branch or jump at a time and waits for the operands.
// It resolves taken/not-taken, computes the target and, when the branch
// is taken, holds a PC redirect until fetch acknowledges it.
module unidad_salto #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_op,
    input  logic [31:0]      br_pc,
    input  logic [25:0]      br_imm,
    input  logic             ops_ready,
    input  logic             cmp_eq,
    output logic             redir_valid,
    output logic [31:0]      redir_target,
    input  logic             redir_ack,
    output logic             flush_ifid,
    output logic             stall_id,
    output logic             res_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ESPERA, RESUELVE, REDIRIGE} state_t;
    typedef enum logic [1:0] {OP_BEQ, OP_BNE, OP_J, OP_RSV} op_t;

    state_t            r_state, w_next;
    op_t               r_op;
    logic [31:0]       r_pc;
    logic [25:0]       r_imm;
    logic [WAIT_W-1:0] r_wait;
    logic              r_redir_valid;
    logic [31:0]       r_redir_target;
    logic              r_flush;
    logic              r_res_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt_total;
    logic [CNT_W-1:0]  r_cnt_taken;

    logic [31:0]       w_pc4;
    logic [31:0]       w_br_target;
    logic [31:0]       w_j_target;
    logic              w_taken;
    logic [31:0]       w_target;

    assign w_pc4       = r_pc + 32'd4;
    assign w_br_target = w_pc4 + {{14{r_imm[15]}}, r_imm[15:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], r_imm, 2'b00};
    assign w_taken     = ((r_op == OP_BEQ) &&  cmp_eq) ||
                         ((r_op == OP_BNE) && !cmp_eq) ||
                          (r_op == OP_J);
    assign w_target    = (r_op == OP_J) ? w_j_target : w_br_target;

    assign br_ready     = (r_state == IDLE);
    assign stall_id     = (r_state != IDLE);
    assign redir_valid  = r_redir_valid;
    assign redir_target = r_redir_target;
    assign flush_ifid   = r_flush;
    assign res_done     = r_res_done;
    assign err_timeout  = r_err;
    assign cnt_total    = r_cnt_total;
    assign cnt_taken    = r_cnt_taken;

    // State register; reset drops any branch in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (br_valid) w_next = ops_ready ? RESUELVE : ESPERA;
            end
            ESPERA: begin
                if (ops_ready)              w_next = RESUELVE;
                else if (r_wait == WAIT_LAST) w_next = IDLE;
            end
            RESUELVE: begin
                w_next = w_taken ? REDIRIGE : IDLE;
            end
            REDIRIGE: begin
                if (redir_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture, wait counter, registered outputs and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op           <= OP_BEQ;
            r_pc           <= '0;
            r_imm          <= '0;
            r_wait         <= '0;
            r_redir_valid  <= 1'b0;
            r_redir_target <= '0;
            r_flush        <= 1'b0;
            r_res_done     <= 1'b0;
            r_err          <= 1'b0;
            r_cnt_total    <= '0;
            r_cnt_taken    <= '0;
        end else begin
            r_flush    <= 1'b0;
            r_res_done <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (br_valid) begin
                        r_op   <= op_t'(br_op);
                        r_pc   <= br_pc;
                        r_imm  <= br_imm;
                        r_wait <= '0;
                    end
                end
                ESPERA: begin
                    if (!ops_ready) begin
                        if (r_wait == WAIT_LAST) begin
                            r_err      <= 1'b1;
                            r_res_done <= 1'b1;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                RESUELVE: begin
                    if (r_cnt_total != '1) r_cnt_total <= r_cnt_total + 1'b1;
                    if (w_taken) begin
                        r_redir_valid  <= 1'b1;
                        r_redir_target <= w_target;
                        r_flush        <= 1'b1;
                        if (r_cnt_taken != '1) r_cnt_taken <= r_cnt_taken + 1'b1;
                    end else begin
                        r_res_done <= 1'b1;
                    end
                end
                REDIRIGE: begin
                    if (redir_ack) begin
                        r_redir_valid <= 1'b0;
                        r_res_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_salto.sv
// tb_unidad_salto: scoreboard bench for unidad_salto (MAX_WAIT=8, CNT_W=4).
module tb_unidad_salto;

    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MAX  = 15;

    localparam int K_NT   = 0;
    localparam int K_TK   = 1;
    localparam int K_TOUT = 2;

    typedef struct {
        int          kind;
        logic [31:0] tgt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             br_valid;
    logic             br_ready;
    logic [1:0]       br_op;
    logic [31:0]      br_pc;
    logic [25:0]      br_imm;
    logic             ops_ready;
    logic             cmp_eq;
    logic             redir_valid;
    logic [31:0]      redir_target;
    logic             redir_ack;
    logic             flush_ifid;
    logic             stall_id;
    logic             res_done;
    logic             err_timeout;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_taken;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    int unsigned exp_total = 0;
    int unsigned exp_taken = 0;
    bit          in_redir = 0;
    logic [31:0] cur_tgt = '0;

    unidad_salto #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_pc(br_pc), .br_imm(br_imm), .ops_ready(ops_ready),
        .cmp_eq(cmp_eq), .redir_valid(redir_valid), .redir_target(redir_target),
        .redir_ack(redir_ack), .flush_ifid(flush_ifid), .stall_id(stall_id),
        .res_done(res_done), .err_timeout(err_timeout),
        .cnt_total(cnt_total), .cnt_taken(cnt_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a flush or a completion
    always @(negedge clk) begin
        if (!rst_n) begin
            in_redir = 0;
        end else begin
            if (flush_ifid) begin
                if (in_redir) begin
                    chk("flush_repulse", 32'(flush_ifid), 32'd0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_redir", 32'(flush_ifid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("redir_kind", 32'(K_TK), 32'(e.kind));
                    chk("redir_valid_first", 32'(redir_valid), 32'd1);
                    chk("redir_target", redir_target, e.tgt);
                    cur_tgt  = e.tgt;
                    in_redir = 1;
                end
            end else if (redir_valid) begin
                if (in_redir) chk("target_stable", redir_target, cur_tgt);
                else          chk("redir_without_flush", 32'(redir_valid), 32'd0);
            end
            if (err_timeout && !res_done)
                chk("err_without_done", 32'(res_done), 32'd1);
            if (res_done) begin
                if (in_redir) begin
                    chk("done_after_ack_valid", 32'(redir_valid), 32'd0);
                    chk("done_after_ack_err", 32'(err_timeout), 32'd0);
                    in_redir = 0;
                end else if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(res_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_kind_not_taken", 32'(e.kind == K_TK), 32'd0);
                    chk("err_timeout", 32'(err_timeout), 32'(e.kind == K_TOUT));
                end
            end
        end
    end

    // One branch: push expectation, drive decode, optionally delay operands, ack redirect
    task automatic run_br(input logic [1:0] op, input logic [31:0] pc, input logic [25:0] imm,
                          input int dly, input logic eq, input int ack_dly,
                          input int kind, input logic [31:0] tgt);
        int  n;
        bit  done;
        exp_t e;
        e.kind = kind;
        e.tgt  = tgt;
        sb.push_back(e);
        if (kind != K_TOUT && exp_total < CNT_MAX) exp_total++;
        if (kind == K_TK && exp_taken < CNT_MAX) exp_taken++;
        @(posedge clk); #1;
        br_valid  = 1'b1;
        br_op     = op;
        br_pc     = pc;
        br_imm    = imm;
        cmp_eq    = eq;
        ops_ready = (dly == 0) && (kind != K_TOUT);
        @(posedge clk); #1;
        br_valid = 1'b0;
        if (kind != K_TOUT) begin
            for (int i = 0; i < dly; i++) begin
                chk("stall_while_wait", 32'(stall_id), 32'd1);
                chk("not_ready_while_wait", 32'(br_ready), 32'd0);
                // decode offers another branch while busy; it must be ignored
                br_valid = 1'b1;
                br_pc    = 32'hDEAD_0000;
                @(posedge clk); #1;
            end
            br_valid  = 1'b0;
            br_pc     = pc;
            ops_ready = 1'b1;
        end
        n    = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (redir_ack) redir_ack = 1'b0;
            if (br_ready) begin
                done = 1;
            end else if (redir_valid) begin
                if (n == ack_dly) redir_ack = 1'b1;
                n++;
            end
        end
        if (!done) chk("wait_idle_bound", 32'(done), 32'd1);
        ops_ready = 1'b0;
        chk("stall_idle", 32'(stall_id), 32'd0);
        chk("cnt_total", 32'(cnt_total), exp_total);
        chk("cnt_taken", 32'(cnt_taken), exp_taken);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_op     = 2'b00;
        br_pc     = '0;
        br_imm    = '0;
        ops_ready = 1'b0;
        cmp_eq    = 1'b0;
        redir_ack = 1'b0;
        #12;
        chk("rst_br_ready", 32'(br_ready), 32'd1);
        chk("rst_stall", 32'(stall_id), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_flush", 32'(flush_ifid), 32'd0);
        chk("rst_res_done", 32'(res_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_cnt_total", 32'(cnt_total), 32'd0);
        chk("rst_cnt_taken", 32'(cnt_taken), 32'd0);
        #10 rst_n = 1'b1;

        run_br(2'b00, 32'h0000_0100, 26'h0004, 0, 1'b1, 0, K_TK, 32'h0000_0114);
        run_br(2'b01, 32'h0000_0200, 26'hFFFF, 0, 1'b1, 0, K_NT, 32'h0);
        run_br(2'b01, 32'h0000_0200, 26'hFFFF, 0, 1'b0, 2, K_TK, 32'h0000_0200);
        run_br(2'b10, 32'h8000_0000, 26'h0000010, 0, 1'b0, 0, K_TK, 32'h8000_0040);
        run_br(2'b00, 32'h0000_0300, 26'h0008, 3, 1'b0, 0, K_NT, 32'h0);
        run_br(2'b00, 32'h0000_1000, 26'h8000, 3, 1'b1, 1, K_TK, 32'hFFFE_1004);
        run_br(2'b00, 32'h0000_0400, 26'h0001, 0, 1'b1, 0, K_TOUT, 32'h0);
        run_br(2'b11, 32'h0000_0600, 26'h0001, 0, 1'b1, 0, K_NT, 32'h0);
        run_br(2'b01, 32'h0000_0040, 26'h0001, 0, 1'b0, 5, K_TK, 32'h0000_0048);
        run_br(2'b00, 32'h0000_0000, 26'h0000, 7, 1'b1, 0, K_TK, 32'h0000_0004);

        // Reset while a redirect is pending
        begin
            exp_t e;
            bit   seen;
            e.kind = K_TK;
            e.tgt  = 32'h0000_0508;
            sb.push_back(e);
            @(posedge clk); #1;
            br_valid  = 1'b1;
            br_op     = 2'b00;
            br_pc     = 32'h0000_0500;
            br_imm    = 26'h0001;
            cmp_eq    = 1'b1;
            ops_ready = 1'b1;
            @(posedge clk); #1;
            br_valid = 1'b0;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk); #1;
                if (redir_valid) seen = 1;
            end
            chk("reset_redir_seen", 32'(seen), 32'd1);
            @(posedge clk); #1;
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            chk("reset_redir_drop", 32'(redir_valid), 32'd0);
            chk("reset_flush_drop", 32'(flush_ifid), 32'd0);
            chk("reset_br_ready", 32'(br_ready), 32'd1);
            chk("reset_stall", 32'(stall_id), 32'd0);
            exp_total = 0;
            exp_taken = 0;
            ops_ready = 1'b0;
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            chk("post_reset_ready", 32'(br_ready), 32'd1);
            chk("post_reset_redir", 32'(redir_valid), 32'd0);
            chk("post_reset_cnt_total", 32'(cnt_total), 32'd0);
            chk("post_reset_cnt_taken", 32'(cnt_taken), 32'd0);
        end

        // Saturation: 20 taken jumps with 4-bit counters
        for (int i = 0; i < 20; i++) begin
            logic [25:0] idx;
            idx = 26'(i + 1);
            run_br(2'b10, 32'h0000_0000, idx, 0, 1'b0, 0, K_TK, {4'h0, idx, 2'b00});
        end
        chk("sat_cnt_total", 32'(cnt_total), 32'd15);
        chk("sat_cnt_taken", 32'(cnt_taken), 32'd15);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
